shalfband_sched: RTL and testbench
==================================

// Module: shalfband_sched
// PURPOSE
//  Sequencer/front-end for one serial half-band filter instance (shalfband).
//  Meters input samples so consecutive filter strobes are >= SPACING clocks apart,
//  holding one early sample in a 1-deep buffer, and reloads the filter's coefficient
//  memory from a valid/ready coefficient stream: filter reset, then NCOEF tap writes.
//  Sits between the sample source / control bus and the filter's tap/ce/reset ports.
// PARAMETERS
//  IW          16    sample width
//  TW          12    coefficient width
//  NCOEF       27    taps written per load (quarter-tap count of a 107-tap half-band)
//  SPACING     108   minimum clocks between consecutive o_ce (>= NTAPS+1 of the filter)
//  OPT_LOAD_ON_RESET 1'b0  1: leave reset straight into a coefficient load
// PORTS
//  i_clk          in   1   clock
//  i_reset        in   1   asynchronous, active-high reset
//  i_ce           in   1   new upstream sample strobe (no backpressure)
//  i_sample       in   IW  upstream sample
//  i_load         in   1   request coefficient reload (one-cycle pulse)
//  i_coef_valid   in   1   coefficient stream valid
//  o_coef_ready   out  1   coefficient stream ready
//  i_coef         in   TW  coefficient data
//  o_filt_reset   out  1   synchronous reset to the filter
//  o_tap_wr       out  1   filter tap write strobe
//  o_tap          out  TW  filter tap data
//  o_ce           out  1   filter sample strobe
//  o_sample       out  IW  filter sample
//  o_busy         out  1   1 whenever state != RUN
//  o_overrun      out  1   sticky: a buffered sample was overwritten
//  o_dropped      out  8   saturating count of samples discarded during FLUSH/LOAD
// BEHAVIOUR
//  Reset values: o_filt_reset=1, o_busy=1; all other outputs 0. State after reset is
//   FLUSH if OPT_LOAD_ON_RESET, else RUN. o_busy deasserts with entry to RUN.
//  States: RUN -> FLUSH on i_load; FLUSH -> LOAD after 1 cycle; LOAD -> RUN the cycle
//   after the NCOEF-th coefficient handshake. i_load outside RUN is ignored.
//  FLUSH: o_filt_reset=1 for exactly one cycle. Pending sample, gap counter and
//   write counter are cleared; o_overrun is cleared.
//  LOAD: o_coef_ready=1. Each i_coef_valid&&o_coef_ready gives o_tap_wr=1 and
//   o_tap=i_coef on the next cycle. Back-to-back handshakes are allowed. o_coef_ready
//   drops the cycle after the NCOEF-th handshake. o_coef_ready=0 in all other states.
//  Gap counter: loads SPACING-1 on every o_ce and decrements to 0. gap_ok = (cnt==0).
//  RUN sample path:
//   - i_ce with buffer empty and gap_ok: o_ce=1 with o_sample=i_sample next cycle
//     (latency 1).
//   - i_ce otherwise: the sample goes into the buffer. If the buffer was already full,
//     the newer sample replaces it and o_overrun is set.
//   - Buffered sample: issued on o_ce the first cycle gap_ok is true.
//   - Simultaneous buffered issue and new i_ce: the buffered sample issues and the new
//     sample fills the buffer.
//   - Resulting o_ce spacing is always >= SPACING.
//  FLUSH/LOAD: i_ce samples are discarded; o_dropped increments, saturating at 255.
//   o_ce=0.
//  o_tap_wr, o_ce and o_filt_reset are never asserted in the same cycle.
//  Async reset mid-LOAD abandons the load. The filter is reset via o_filt_reset=1, and
//   partially written taps remain until the next complete load.
// TESTING
//  1. After reset, i_ce at cycles 10 and 200 -> o_ce at cycles 11 and 201,
//     o_sample matches each input.
//  2. i_ce at cycles 10, 20, 30 (samples 1, 2, 3) -> o_ce at 11 (1) and at 11+108=119 (3);
//     o_overrun=1.
//  3. i_load, then 27 coefs 0x001..0x01B with valid always high -> filter reset 1 cycle,
//     27 consecutive o_tap_wr with matching data, o_busy falls after the 27th write.
//  4. Load with i_coef_valid toggling every other cycle -> still exactly 27 writes,
//     in order, no extra writes.
//  5. 300 i_ce during LOAD -> no o_ce, o_dropped=255; first sample after RUN issues
//     with latency 1.
//  6. Assert i_reset after the 10th tap write -> outputs return to reset values
//     immediately; o_coef_ready=0.

Source files
------------

// File: rtl/shalfband_sched.sv
// shalfband_sched: front-end sequencer for one serial half-band filter.
// Meters upstream samples so filter strobes are at least SPACING clocks apart,
// using a 1-deep holding buffer. It also reloads the filter's coefficient memory
// from a valid/ready stream: one filter-reset cycle, then NCOEF tap writes.
module shalfband_sched #(
  parameter int   IW                = 16,
  parameter int   TW                = 12,
  parameter int   NCOEF             = 27,
  parameter int   SPACING           = 108,
  parameter logic OPT_LOAD_ON_RESET = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [IW-1:0] i_sample,
  input  logic          i_load,
  input  logic          i_coef_valid,
  output logic          o_coef_ready,
  input  logic [TW-1:0] i_coef,
  output logic          o_filt_reset,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  output logic          o_ce,
  output logic [IW-1:0] o_sample,
  output logic          o_busy,
  output logic          o_overrun,
  output logic [7:0]    o_dropped
);

  localparam int GW = $clog2(SPACING + 1);
  localparam int WW = $clog2(NCOEF + 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(SPACING - 1);
  localparam logic [WW-1:0] LAST_WR    = WW'(NCOEF - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t          state;
  logic [WW-1:0]   wr_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            pend_valid;
  logic [IW-1:0]   pend_data;
  logic            gap_ok;
  logic            handshake;
  logic            run_active;
  logic            discard;

  assign gap_ok     = (gap_cnt == '0);
  assign handshake  = i_coef_valid && o_coef_ready;
  // A load request takes the cycle away from the sample path so that o_ce can
  // never coincide with the filter reset issued on the following cycle.
  assign run_active = (state == S_RUN) && !i_load;
  assign discard    = i_ce && !run_active;

  // Control FSM: state sequencing, filter reset pulse, coefficient handshake and tap writes
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= OPT_LOAD_ON_RESET ? S_FLUSH : S_RUN;
      o_filt_reset <= 1'b1;
      o_busy       <= 1'b1;
      o_coef_ready <= 1'b0;
      o_tap_wr     <= 1'b0;
      o_tap        <= '0;
      wr_cnt       <= '0;
    end else begin
      o_tap_wr     <= 1'b0;
      o_filt_reset <= 1'b0;
      case (state)
        S_RUN: begin
          if (i_load) begin
            state        <= S_FLUSH;
            o_filt_reset <= 1'b1;
            o_busy       <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        S_FLUSH: begin
          state        <= S_LOAD;
          wr_cnt       <= '0;
          o_coef_ready <= 1'b1;
          o_busy       <= 1'b1;
        end
        S_LOAD: begin
          if (handshake) begin
            o_tap_wr <= 1'b1;
            o_tap    <= i_coef;
            if (wr_cnt == LAST_WR) begin
              state        <= S_RUN;
              o_coef_ready <= 1'b0;
              o_busy       <= 1'b0;
              wr_cnt       <= '0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        default: begin
          state        <= S_RUN;
          o_coef_ready <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Sample metering: direct issue, 1-deep buffer, gap counter and overrun flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ce       <= 1'b0;
      o_sample   <= '0;
      o_overrun  <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      gap_cnt    <= '0;
    end else begin
      o_ce <= 1'b0;
      if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;

      if (run_active) begin
        if (pend_valid && gap_ok) begin
          // Buffered sample goes first; a coincident new sample refills the buffer.
          o_ce      <= 1'b1;
          o_sample  <= pend_data;
          gap_cnt   <= GAP_RELOAD;
          if (i_ce)
            pend_data <= i_sample;
          else
            pend_valid <= 1'b0;
        end else if (i_ce && gap_ok) begin
          o_ce     <= 1'b1;
          o_sample <= i_sample;
          gap_cnt  <= GAP_RELOAD;
        end else if (i_ce) begin
          if (pend_valid)
            o_overrun <= 1'b1;
          pend_valid <= 1'b1;
          pend_data  <= i_sample;
        end
      end else if (state == S_FLUSH) begin
        pend_valid <= 1'b0;
        gap_cnt    <= '0;
        o_overrun  <= 1'b0;
      end
    end
  end

  // Saturating count of samples discarded while the filter is being reloaded
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_dropped <= '0;
    end else if (discard && (o_dropped != '1)) begin
      o_dropped <= o_dropped + 1'b1;
    end
  end

endmodule

// File: tb/tb_shalfband_sched.sv
// Directed bench for shalfband_sched: table of sample-metering scenarios plus
// hand-written coefficient-load sequences (continuous, gapped, flooded, aborted).
module tb_shalfband_sched;

  localparam int IW      = 16;
  localparam int TW      = 12;
  localparam int NCOEF   = 27;
  localparam int SPACING = 108;

  logic          clk;
  logic          rst;
  logic          ce;
  logic [IW-1:0] smp;
  logic          load;
  logic          cvalid;
  logic          cready;
  logic [TW-1:0] coef;
  logic          filt_reset;
  logic          tap_wr;
  logic [TW-1:0] tap;
  logic          oce;
  logic [IW-1:0] osmp;
  logic          busy;
  logic          overrun;
  logic [7:0]    dropped;

  shalfband_sched #(
    .IW(IW), .TW(TW), .NCOEF(NCOEF), .SPACING(SPACING), .OPT_LOAD_ON_RESET(1'b0)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sample(smp), .i_load(load),
    .i_coef_valid(cvalid), .o_coef_ready(cready), .i_coef(coef),
    .o_filt_reset(filt_reset), .o_tap_wr(tap_wr), .o_tap(tap), .o_ce(oce),
    .o_sample(osmp), .o_busy(busy), .o_overrun(overrun), .o_dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          len;
    int          n_in;
    int          in_cyc[4];
    logic [15:0] in_smp[4];
    int          n_out;
    int          out_cyc[4];
    logic [15:0] out_smp[4];
    logic        ovr;
  } scen_t;

  typedef struct {
    int writes;
    int bad;
    int first;
    int last;
    int fr;
    int overlap;
    int ce_seen;
    int busy_last;
    int busy_prev;
    int timeout;
  } load_res_t;

  scen_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; load = 1'b0; cvalid = 1'b0; smp = '0; coef = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_scen(input int idx);
    int          got;
    int          got_cyc[4];
    logic [15:0] got_smp[4];
    got = 0;
    for (int j = 0; j < 4; j++) begin got_cyc[j] = -1; got_smp[j] = '0; end
    do_reset();
    for (int c = 0; c <= tbl[idx].len; c++) begin
      if (oce) begin
        if (got < 4) begin got_cyc[got] = cyc; got_smp[got] = osmp; end
        got++;
      end
      ce = 1'b0;
      for (int j = 0; j < tbl[idx].n_in; j++)
        if (tbl[idx].in_cyc[j] == cyc) begin ce = 1'b1; smp = tbl[idx].in_smp[j]; end
      step();
    end
    ce = 1'b0;
    check($sformatf("scen%0d o_ce count", idx), got, tbl[idx].n_out);
    for (int j = 0; j < tbl[idx].n_out; j++) begin
      check($sformatf("scen%0d o_ce[%0d] cycle", idx, j), got_cyc[j], tbl[idx].out_cyc[j]);
      check($sformatf("scen%0d o_sample[%0d]", idx, j), 32'(got_smp[j]), 32'(tbl[idx].out_smp[j]));
    end
    check($sformatf("scen%0d o_overrun", idx), 32'(overrun), 32'(tbl[idx].ovr));
  endtask

  // mode 0: valid always high; 1: valid every other cycle; 2: valid after 300
  // cycles with i_ce asserted throughout the busy period
  task automatic run_load(input int mode, input int abort_after, output load_res_t r);
    int   c0;
    int   k;
    int   done_at;
    logic hs;
    logic prev_busy;
    r = '{writes: 0, bad: 0, first: -1, last: -1, fr: 0, overlap: 0, ce_seen: 0,
          busy_last: -1, busy_prev: -1, timeout: 1};
    c0 = cyc; k = 0; done_at = -1; prev_busy = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (tap_wr) begin
        r.writes++;
        if (tap !== TW'(r.writes)) r.bad++;
        if (r.first < 0) r.first = cyc - c0;
        r.last = cyc - c0;
        r.busy_last = int'(busy);
        r.busy_prev = int'(prev_busy);
      end
      if (filt_reset) r.fr++;
      if (int'(tap_wr) + int'(oce) + int'(filt_reset) > 1) r.overlap++;
      if (oce) r.ce_seen++;
      prev_busy = busy;
      if (abort_after > 0 && r.writes == abort_after) begin r.timeout = 0; break; end
      if (done_at < 0 && r.writes >= NCOEF && !busy) done_at = i;
      if (done_at >= 0 && i >= done_at + 20) begin r.timeout = 0; break; end
      case (mode)
        0: cvalid = 1'b1;
        1: cvalid = (cyc % 2 == 1);
        default: begin
          cvalid = ((cyc - c0) >= 300);
          ce     = busy;
          smp    = 16'h5A5A;
        end
      endcase
      coef = TW'(k + 1);
      hs = cvalid && cready;
      step();
      if (hs) k++;
    end
    cvalid = 1'b0;
    ce = 1'b0;
  endtask

  task automatic check_load(input string tag, input load_res_t r, input logic timing);
    check({tag, " timeout"}, r.timeout, 0);
    check({tag, " tap writes"}, r.writes, NCOEF);
    check({tag, " tap data errors"}, r.bad, 0);
    check({tag, " filt_reset cycles"}, r.fr, 1);
    check({tag, " strobe overlap"}, r.overlap, 0);
    check({tag, " o_ce during load"}, r.ce_seen, 0);
    check({tag, " busy at last write"}, r.busy_last, 0);
    check({tag, " busy before last write"}, r.busy_prev, 1);
    if (timing) begin
      check({tag, " first write offset"}, r.first, 3);
      check({tag, " last write offset"}, r.last, 3 + NCOEF - 1);
    end
    check({tag, " coef_ready after"}, 32'(cready), 0);
    check({tag, " busy after"}, 32'(busy), 0);
  endtask

  initial begin
    load_res_t r;

    tbl[0] = '{len: 260, n_in: 2, in_cyc: '{10, 200, 0, 0}, in_smp: '{16'h1111, 16'h2222, 0, 0},
               n_out: 2, out_cyc: '{11, 201, 0, 0}, out_smp: '{16'h1111, 16'h2222, 0, 0}, ovr: 1'b0};
    tbl[1] = '{len: 240, n_in: 3, in_cyc: '{10, 20, 30, 0}, in_smp: '{16'd1, 16'd2, 16'd3, 0},
               n_out: 2, out_cyc: '{11, 119, 0, 0}, out_smp: '{16'd1, 16'd3, 0, 0}, ovr: 1'b1};
    tbl[2] = '{len: 200, n_in: 2, in_cyc: '{10, 117, 0, 0}, in_smp: '{16'hA001, 16'hA002, 0, 0},
               n_out: 2, out_cyc: '{11, 119, 0, 0}, out_smp: '{16'hA001, 16'hA002, 0, 0}, ovr: 1'b0};
    tbl[3] = '{len: 200, n_in: 2, in_cyc: '{10, 118, 0, 0}, in_smp: '{16'hB001, 16'hB002, 0, 0},
               n_out: 2, out_cyc: '{11, 119, 0, 0}, out_smp: '{16'hB001, 16'hB002, 0, 0}, ovr: 1'b0};
    tbl[4] = '{len: 200, n_in: 2, in_cyc: '{10, 119, 0, 0}, in_smp: '{16'hC001, 16'hC002, 0, 0},
               n_out: 2, out_cyc: '{11, 120, 0, 0}, out_smp: '{16'hC001, 16'hC002, 0, 0}, ovr: 1'b0};
    tbl[5] = '{len: 300, n_in: 3, in_cyc: '{10, 50, 118, 0}, in_smp: '{16'hD001, 16'hD002, 16'hD003, 0},
               n_out: 3, out_cyc: '{11, 119, 227, 0}, out_smp: '{16'hD001, 16'hD002, 16'hD003, 0}, ovr: 1'b0};

    // reset values while reset is held
    rst = 1'b1; ce = 1'b0; load = 1'b0; cvalid = 1'b0; smp = '0; coef = '0;
    #1;
    check("rst filt_reset", 32'(filt_reset), 1);
    check("rst busy", 32'(busy), 1);
    check("rst coef_ready", 32'(cready), 0);
    check("rst tap_wr", 32'(tap_wr), 0);
    check("rst tap", 32'(tap), 0);
    check("rst o_ce", 32'(oce), 0);
    check("rst o_sample", 32'(osmp), 0);
    check("rst overrun", 32'(overrun), 0);
    check("rst dropped", 32'(dropped), 0);
    do_reset();
    step();
    check("post-reset busy", 32'(busy), 0);
    check("post-reset filt_reset", 32'(filt_reset), 0);

    for (int s = 0; s < 6; s++) run_scen(s);

    // continuous load, then gapped load, then flooded load
    do_reset();
    step(); step();
    run_load(0, 0, r);
    check_load("load_cont", r, 1'b1);
    check("load_cont dropped", 32'(dropped), 0);
    run_load(1, 0, r);
    check_load("load_gap", r, 1'b0);
    run_load(2, 0, r);
    check_load("load_flood", r, 1'b0);
    check("load_flood dropped", 32'(dropped), 255);
    ce = 1'b1; smp = 16'hBEEF;
    step();
    ce = 1'b0;
    check("after flood o_ce", 32'(oce), 1);
    check("after flood o_sample", 32'(osmp), 32'h0000BEEF);

    // async reset after the 10th tap write
    run_load(0, 10, r);
    check("abort timeout", r.timeout, 0);
    check("abort writes", r.writes, 10);
    #2;
    rst = 1'b1;
    #1;
    check("abort filt_reset", 32'(filt_reset), 1);
    check("abort busy", 32'(busy), 1);
    check("abort coef_ready", 32'(cready), 0);
    check("abort tap_wr", 32'(tap_wr), 0);
    check("abort tap", 32'(tap), 0);
    check("abort dropped", 32'(dropped), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(); step();
    check("abort recover busy", 32'(busy), 0);
    check("abort recover coef_ready", 32'(cready), 0);
    ce = 1'b1; smp = 16'h1234;
    step();
    ce = 1'b0;
    check("abort recover o_ce", 32'(oce), 1);
    check("abort recover o_sample", 32'(osmp), 32'h00001234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
